instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter N_param, default 32, meaning instruction and address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning instruction queue entries (power of two, at least 2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_en, input, 1 bit: fetch enable.
REQ-007 SHALL have port o_imem_req, output, 1 bit: fetch request.
REQ-008 SHALL have port o_imem_addr, output, N_param bits: request address.
REQ-009 SHALL have port i_imem_gnt, input, 1 bit: request accepted this cycle.
REQ-010 SHALL have port i_imem_rvalid, input, 1 bit: response valid; responses return in order, one or more cycles after grant.
REQ-011 SHALL have port i_imem_rdata, input, N_param bits: response instruction word.
REQ-012 SHALL have port o_valid, output, 1 bit: an instruction is presented to decode.
REQ-013 SHALL have port i_ready, input, 1 bit: decode consumes the presented instruction.
REQ-014 SHALL have port o_instruction, output, N_param bits: head instruction, fed to decode "instruction".
REQ-015 SHALL have port o_pc, output, N_param bits: PC of the head instruction.
REQ-016 SHALL have port i_redirect, input, 1 bit: branch/jump/trap redirect.
REQ-017 SHALL have port i_redirect_pc, input, N_param bits: redirect target.
REQ-018 SHALL have port o_fault, output, 1 bit: misaligned redirect, present only under FETCH_MISALIGN_TRAP_EN.

Function
REQ-019 SHALL use FSM states S_IDLE, S_FETCH and S_FAULT; S_IDLE->S_FETCH when i_en=1, S_FETCH->S_IDLE when i_en=0, S_FAULT per REQ-031.
REQ-020 SHALL assert o_imem_req in S_FETCH only while (outstanding + FIFO occupancy) < FIFO_DEPTH, so that the FIFO can never overflow.
REQ-021 SHALL hold o_imem_addr stable while o_imem_req=1 and i_imem_gnt=0, except on redirect.
REQ-022 SHALL, on o_imem_req&i_imem_gnt, increment the fetch PC by 4 and the outstanding count by 1 (saturation is impossible by REQ-020).
REQ-023 SHALL push {addr, i_imem_rdata} into the FIFO on i_imem_rvalid when the drop count is 0, and otherwise decrement the drop count and discard the response.
REQ-024 SHALL drive o_valid = FIFO not empty; o_instruction/o_pc come from the FIFO head; a response at cycle t is visible at t+1 at the earliest.
REQ-025 SHALL pop the FIFO on o_valid&i_ready; a simultaneous push and pop leaves occupancy unchanged.
REQ-026 SHALL, on i_redirect, set the fetch PC to i_redirect_pc, flush the FIFO (o_valid=0 next cycle), set the drop count to all outstanding responses (including any granted the same cycle, excluding any arriving the same cycle), and withdraw any ungranted request.
REQ-027 SHALL give i_redirect priority over pop, push and i_en deassertion in the same cycle.
REQ-028 SHALL let the outstanding count track granted-but-unreturned requests regardless of dropping.

Reset
REQ-029 SHALL, while i_rst_n=0, immediately force: state S_IDLE, fetch PC=RESET_PC, FIFO empty, outstanding=0, drop=0, o_imem_req=0, o_valid=0, o_fault=0, o_instruction=0, o_pc=0, o_imem_addr=RESET_PC.
REQ-030 SHALL require the memory to discard in-flight responses across reset; responses arriving after reset deassertion that were not granted after it are a system error.

Configuration
REQ-031 SHALL, with FETCH_MISALIGN_TRAP_EN defined, enter S_FAULT, assert o_fault and issue no requests on a redirect with i_redirect_pc[1:0]!=0, leaving S_FAULT only on an aligned redirect (to S_FETCH) or on reset.
REQ-032 SHALL, without FETCH_MISALIGN_TRAP_EN, omit o_fault and S_FAULT and force i_redirect_pc[1:0] to 0.

Structure
REQ-033 SHALL place FSM state encodings and the RESET_PC default in the shared package alongside the existing opcode/instruction-type defines.
REQ-034 SHALL implement the instruction queue as sub-module fetch_fifo (synchronous FIFO with count output); all other logic lives in instr_fetch.

Verification
REQ-035 Reset, i_en=1, gnt=1, 1-cycle rvalid, ready=1 -> o_pc sequence 0,4,8,12, with the first o_valid 3 cycles after reset release.
REQ-036 i_ready=0 for 10 cycles -> exactly 4 requests granted, o_imem_req=0 afterwards, and no instruction is lost when ready returns.
REQ-037 Redirect to 0x100 with 2 outstanding -> the 2 responses are dropped, and the next o_valid shows o_pc=0x100.
REQ-038 Redirect in the same cycle as an rvalid and a gnt -> the arriving response is discarded with the flush, the granted request is dropped later, and the first valid o_pc equals the target.
REQ-039 gnt held 0 for 5 cycles -> o_imem_addr is constant; i_en=0 mid-stream -> no new requests and the FIFO still drains.
REQ-040 FETCH_MISALIGN_TRAP_EN defined, redirect to 0x102 -> o_fault=1 with no requests; redirect to 0x200 -> o_fault=0 and fetch resumes at 0x200; undefined -> fetch occurs at 0x100.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: opcodes, instruction types, fetch FSM states and reset PC.
// Latency: none (types and constants only).
// Backpressure: not applicable. S_FAULT exists only when FETCH_MISALIGN_TRAP_EN is defined.
package instr_fetch_pkg;

   // Major opcodes seen by decode
   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OP_IMM = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111,
      OPC_SYSTEM = 7'b1110011
   } opcode_e;

   // Instruction encoding formats
   typedef enum logic [2:0] {
      ITYPE_R,
      ITYPE_I,
      ITYPE_S,
      ITYPE_B,
      ITYPE_U,
      ITYPE_J
   } instr_type_e;

   // Fetch FSM encodings
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      S_FAULT = 2'd2
`endif
   } fetch_state_e;

   // Default first fetch address
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: synchronous instruction queue holding {pc, instruction} entries, with flush and occupancy count.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller never pushes when full nor pops when empty.
module fetch_fifo #(
   parameter int unsigned W     = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [W-1:0]               data_i,
   input  logic                       pop_i,
   output logic [W-1:0]               data_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   cnt_q;

   // Storage write; contents need no reset because the count gates visibility
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Pointers and occupancy; flush empties the queue and wins over push/pop
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_i) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: in-order imem requests, response queue, {pc, instruction} handed to decode.
// Latency: first request one cycle after enable; a response returning in cycle t shows on o_valid at t+1.
// Backpressure: requests stop once outstanding + queued reaches FIFO_DEPTH; i_ready=0 holds the head.
// Option: FETCH_MISALIGN_TRAP_EN adds o_fault and the S_FAULT state for misaligned redirect targets.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int unsigned        N_param    = 32,
   parameter int unsigned        FIFO_DEPTH = 4,
   parameter logic [N_param-1:0] RESET_PC   = N_param'(RESET_PC_DEFAULT)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   output logic               o_imem_req,
   output logic [N_param-1:0] o_imem_addr,
   input  logic               i_imem_gnt,
   input  logic               i_imem_rvalid,
   input  logic [N_param-1:0] i_imem_rdata,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [N_param-1:0] o_instruction,
   output logic [N_param-1:0] o_pc,
   input  logic               i_redirect,
   input  logic [N_param-1:0] i_redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic               o_fault
`endif
);
   localparam int unsigned   CW      = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned   DW      = 2 * N_param;
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

   fetch_state_e       state_q, state_d;
   logic [N_param-1:0] pc_q, pc_d;
   logic [N_param-1:0] rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]      outst_q, outst_d;
   logic [CW-1:0]      drop_q, drop_d;
   logic [CW-1:0]      fifo_cnt;
   logic [N_param-1:0] redir_pc;
   logic               req;
   logic               gnt_fire;
   logic               push;
   logic               pop;
   logic               flush;
   logic               fifo_empty;
   logic [DW-1:0]      head;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic redir_misaligned;
   assign redir_pc         = i_redirect_pc;
   assign redir_misaligned = |i_redirect_pc[1:0];
   assign o_fault          = (state_q == S_FAULT);
`else
   // Without the trap, targets are word-aligned by clearing the low two bits
   assign redir_pc = i_redirect_pc & ~N_param'(3);
`endif

   // Next FSM state and request qualification; a redirect keeps an active fetch running
   always_comb begin
      state_d = state_q;
      req     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_en) state_d = S_FETCH;
         end
         S_FETCH: begin
            req = ({1'b0, outst_q} + {1'b0, fifo_cnt}) < DEPTH_C;
            if (!i_en) state_d = S_IDLE;
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         S_FAULT: begin
            state_d = S_FAULT;
         end
`endif
         default: state_d = S_IDLE;
      endcase
      if (i_redirect) begin
         if (state_q == S_FETCH) state_d = S_FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
         if (redir_misaligned) begin
            state_d = S_FAULT;
         end else if (state_q == S_FAULT) begin
            state_d = S_FETCH;
         end
`endif
      end
   end

   assign o_imem_req  = req;
   assign o_imem_addr = pc_q;
   assign gnt_fire    = req & i_imem_gnt;

   // Fetch PC, response PC, in-flight/drop counters and queue control; redirect has priority
   always_comb begin
      pc_d     = pc_q;
      rsp_pc_d = rsp_pc_q;
      outst_d  = outst_q + CW'(gnt_fire) - CW'(i_imem_rvalid);
      drop_d   = drop_q;
      push     = 1'b0;
      flush    = 1'b0;
      pop      = o_valid & i_ready & ~i_redirect;
      if (gnt_fire) begin
         pc_d = pc_q + N_param'(4);
      end
      if (i_redirect) begin
         // Everything still in flight after this cycle belongs to the old path
         flush    = 1'b1;
         pc_d     = redir_pc;
         rsp_pc_d = redir_pc;
         drop_d   = outst_d;
      end else if (i_imem_rvalid) begin
         if (drop_q != '0) begin
            drop_d = drop_q - CW'(1);
         end else begin
            push     = 1'b1;
            rsp_pc_d = rsp_pc_q + N_param'(4);
         end
      end
   end

   // State registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         outst_q  <= '0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         outst_q  <= outst_d;
         drop_q   <= drop_d;
      end
   end

   fetch_fifo #(
      .W     (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .flush_i (flush),
      .push_i  (push),
      .data_i  ({rsp_pc_q, i_imem_rdata}),
      .pop_i   (pop),
      .data_o  (head),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   assign o_valid       = ~fifo_empty;
   assign o_pc          = o_valid ? head[DW-1:N_param] : '0;
   assign o_instruction = o_valid ? head[N_param-1:0]  : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a simple in-order memory model.
// Latency: memory answers one cycle after grant unless responses are held back.
// Backpressure: exercised through i_ready, i_imem_gnt and held responses.
`timescale 1ns/1ps
module tb_instr_fetch;
   logic        i_clk         = 1'b0;
   logic        i_rst_n       = 1'b1;
   logic        i_en          = 1'b0;
   logic        i_imem_gnt    = 1'b0;
   logic        i_imem_rvalid = 1'b0;
   logic [31:0] i_imem_rdata  = '0;
   logic        i_ready       = 1'b0;
   logic        i_redirect    = 1'b0;
   logic [31:0] i_redirect_pc = '0;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        o_valid;
   logic [31:0] o_instruction;
   logic [31:0] o_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        o_fault;
`endif

   int          checks = 0;
   int          errors = 0;
   int          grants = 0;
   int          g0     = 0;
   logic        rsp_en = 1'b1;
   logic [31:0] pend_q[$];
   logic [31:0] pop_pc_q[$];
   logic [31:0] pop_ins_q[$];

   instr_fetch dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_en          (i_en),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (i_imem_gnt),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_instruction (o_instruction),
      .o_pc          (o_pc),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .o_fault       (o_fault)
`endif
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes before the edge, update the memory model after it
   task automatic step();
      logic        fire;
      logic [31:0] a;
      #2;
      fire = i_rst_n & o_imem_req & i_imem_gnt;
      a    = o_imem_addr;
      if (i_rst_n && o_valid && i_ready && !i_redirect) begin
         pop_pc_q.push_back(o_pc);
         pop_ins_q.push_back(o_instruction);
      end
      @(posedge i_clk);
      #1;
      if (fire) begin
         pend_q.push_back(a);
         grants++;
      end
      if (rsp_en && pend_q.size() > 0) begin
         i_imem_rvalid = 1'b1;
         i_imem_rdata  = mem_word(pend_q.pop_front());
      end else begin
         i_imem_rvalid = 1'b0;
         i_imem_rdata  = '0;
      end
   endtask

   task automatic clear_pops();
      pop_pc_q.delete();
      pop_ins_q.delete();
   endtask

   task automatic do_reset();
      i_rst_n       = 1'b0;
      i_en          = 1'b0;
      i_imem_gnt    = 1'b0;
      i_ready       = 1'b0;
      i_redirect    = 1'b0;
      i_redirect_pc = '0;
      rsp_en        = 1'b1;
      step();
      step();
      pend_q.delete();
      clear_pops();
      grants        = 0;
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = '0;
      i_rst_n       = 1'b1;
   endtask

   // Decode must see n consecutive words starting at base, each carrying its own memory data
   task automatic chk_stream(input string tag, input logic [31:0] base, input int n);
      check({tag, "_count"}, 32'(pop_pc_q.size() >= n), 32'd1);
      for (int k = 0; k < n; k++) begin
         if (k < pop_pc_q.size()) begin
            check({tag, "_pc"},  pop_pc_q[k],  base + 32'(4 * k));
            check({tag, "_ins"}, pop_ins_q[k], mem_word(base + 32'(4 * k)));
         end
      end
   endtask

   initial begin
      // Reset values, applied asynchronously
      #1 i_rst_n = 1'b0;
      i_en = 1'b1;
      #1;
      check("rst_req",   32'(o_imem_req), 32'd0);
      check("rst_valid", 32'(o_valid),    32'd0);
      check("rst_addr",  o_imem_addr,     32'h0);
      check("rst_pc",    o_pc,            32'h0);
      check("rst_ins",   o_instruction,   32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("rst_fault", 32'(o_fault),    32'd0);
`endif
      step();
      check("rst_req_held", 32'(o_imem_req), 32'd0);

      // Streaming: first valid three edges after release, pc 0,4,8,12
      do_reset();
      i_en = 1'b1; i_imem_gnt = 1'b1; i_ready = 1'b1;
      step(); check("t2_valid_c1", 32'(o_valid), 32'd0);
      step(); check("t2_valid_c2", 32'(o_valid), 32'd0);
      step(); check("t2_valid_c3", 32'(o_valid), 32'd1);
      check("t2_first_pc", o_pc, 32'h0);
      repeat (6) step();
      chk_stream("t2", 32'h0, 4);

      // Decode stalled: queue fills after exactly four grants, nothing lost afterwards
      do_reset();
      i_en = 1'b1; i_imem_gnt = 1'b1; i_ready = 1'b0;
      repeat (10) step();
      check("t3_grants", 32'(grants), 32'd4);
      check("t3_req_off", 32'(o_imem_req), 32'd0);
      check("t3_valid", 32'(o_valid), 32'd1);
      check("t3_head_pc", o_pc, 32'h0);
      i_ready = 1'b1;
      repeat (12) step();
      chk_stream("t3", 32'h0, 8);

      // Redirect with two responses in flight
      do_reset();
      i_en = 1'b1; i_imem_gnt = 1'b1; i_ready = 1'b1; rsp_en = 1'b0;
      repeat (3) step();
      i_imem_gnt = 1'b0;
      check("t4_inflight", 32'(grants), 32'd2);
      i_redirect = 1'b1; i_redirect_pc = 32'h100;
      step();
      i_redirect = 1'b0;
      check("t4_addr", o_imem_addr, 32'h100);
      check("t4_valid", 32'(o_valid), 32'd0);
      i_imem_gnt = 1'b1; rsp_en = 1'b1;
      repeat (14) step();
      chk_stream("t4", 32'h100, 4);

      // Redirect coinciding with a returning response and a grant
      do_reset();
      i_en = 1'b1; i_imem_gnt = 1'b1; i_ready = 1'b0;
      repeat (3) step();
      check("t5_pre_valid", 32'(o_valid), 32'd1);
      check("t5_pre_req", 32'(o_imem_req), 32'd1);
      i_redirect = 1'b1; i_redirect_pc = 32'h200;
      step();
      i_redirect = 1'b0;
      check("t5_flush", 32'(o_valid), 32'd0);
      check("t5_grants", 32'(grants), 32'd3);
      check("t5_addr", o_imem_addr, 32'h200);
      i_ready = 1'b1;
      repeat (14) step();
      chk_stream("t5", 32'h200, 4);

      // Grant withheld: address holds; then enable drops and the queue drains
      do_reset();
      i_en = 1'b1; i_imem_gnt = 1'b0; i_ready = 1'b1;
      step();
      check("t6_req_wait", 32'(o_imem_req), 32'd1);
      for (int k = 0; k < 5; k++) begin
         step();
         check("t6_addr_hold", o_imem_addr, 32'h0);
      end
      i_imem_gnt = 1'b1;
      step();
      step();
      i_en = 1'b0;
      step();
      check("t6_grants", 32'(grants), 32'd3);
      g0 = grants;
      repeat (8) step();
      check("t6_no_new", 32'(grants - g0), 32'd0);
      check("t6_req_off", 32'(o_imem_req), 32'd0);
      check("t6_drained", 32'(o_valid), 32'd0);
      check("t6_pops", 32'(pop_pc_q.size()), 32'd3);
      chk_stream("t6", 32'h0, 3);

      // Misaligned redirect target
      do_reset();
      i_en = 1'b1; i_imem_gnt = 1'b1; i_ready = 1'b1;
      repeat (4) step();
      i_redirect = 1'b1; i_redirect_pc = 32'h102;
      step();
      i_redirect = 1'b0;
      clear_pops();
`ifdef FETCH_MISALIGN_TRAP_EN
      check("t7_fault", 32'(o_fault), 32'd1);
      g0 = grants;
      repeat (6) step();
      check("t7_no_req", 32'(grants - g0), 32'd0);
      check("t7_req_off", 32'(o_imem_req), 32'd0);
      check("t7_fault_held", 32'(o_fault), 32'd1);
      check("t7_empty", 32'(o_valid), 32'd0);
      i_redirect = 1'b1; i_redirect_pc = 32'h200;
      step();
      i_redirect = 1'b0;
      clear_pops();
      check("t7_fault_clr", 32'(o_fault), 32'd0);
      repeat (14) step();
      chk_stream("t7", 32'h200, 3);
`else
      check("t7_addr", o_imem_addr, 32'h100);
      repeat (14) step();
      chk_stream("t7", 32'h100, 3);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
